ual: RTL and testbench



---
 rtl/ual_pkg.sv | 49 ++++
 rtl/ual_alu.sv | 75 +++++++
 rtl/ual.sv | 113 +++++++++++
 tb/tb_ual.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ual_pkg.sv
// +--------------------------------------------------------------------+
// | ual_pkg : opcodes, register codes, shift sub-ops and flag indices   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package ual_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_MOV  = 4'b0001,
    OP_CMP  = 4'b0010,
    OP_RSV  = 4'b0011,
    OP_HIX  = 4'b0100,
    OP_LOX  = 4'b0101,
    OP_HIV  = 4'b0110,
    OP_LOV  = 4'b0111,
    OP_ADD  = 4'b1000,
    OP_SUB  = 4'b1001,
    OP_SHF  = 4'b1010,
    OP_AND  = 4'b1011,
    OP_OR   = 4'b1100,
    OP_XOR  = 4'b1101,
    OP_NAND = 4'b1110,
    OP_NOT  = 4'b1111
  } opcode_e;

  // Source code for s/d; as a destination REG_IN means OUT and REG_MEM means discard.
  typedef enum logic [1:0] {
    REG_IN  = 2'b00,
    REG_MEM = 2'b01,
    REG_V   = 2'b10,
    REG_X   = 2'b11
  } reg_e;

  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ROL = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;
  localparam int FLAG_P = 4;

endpackage

`default_nettype wire

// File: rtl/ual_alu.sv
// +--------------------------------------------------------------------+
// | ual_alu : combinational 8-bit ALU, result plus next flags           |
// | Optional UAL_PARITY_EN enables the even-parity flag.                |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module ual_alu
  import ual_pkg::*;
(
  input  opcode_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] shift_op,
  output logic [7:0] result,
  output logic [4:0] flags_next
);

  logic [8:0] wide;
  logic       carry;
  logic       ovf;

  always_comb begin
    wide   = '0;
    result = a;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_MOV: result = b;
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (a[7] == b[7]) && (wide[7] != a[7]);
      end
      OP_SUB, OP_CMP: begin
        // Bit 8 of the 9-bit difference is the borrow (a < b unsigned).
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[7:0];
        carry  = wide[8];
        ovf    = (a[7] != b[7]) && (wide[7] != a[7]);
      end
      OP_SHF: begin
        case (shift_op)
          SH_SHL: begin result = {a[6:0], 1'b0}; carry = a[7]; end
          SH_SHR: begin result = {1'b0, a[7:1]}; carry = a[0]; end
          SH_ROL: begin result = {a[6:0], a[7]}; carry = a[7]; end
          default: begin result = {a[0], a[7:1]}; carry = a[0]; end
        endcase
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOT:  result = ~b;
      default: result = a;
    endcase
  end

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_C] = carry;
    flags_next[FLAG_Z] = (result == 8'h00);
    flags_next[FLAG_N] = result[7];
    flags_next[FLAG_O] = ovf;
`ifdef UAL_PARITY_EN
    flags_next[FLAG_P] = ~^result;
`else
    flags_next[FLAG_P] = 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/ual.sv
// +--------------------------------------------------------------------+
// | ual : SIMP datapath core - V/X registers, flags, OUT port           |
// | Optional UAL_PARITY_EN enables the even-parity flag.                |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module ual
  import ual_pkg::*;
(
  input  logic       ck,
  input  logic       rst_n,
  input  logic [7:0] instr,
  output logic [7:0] r1,
  output logic [7:0] r2,
  output logic [4:0] flags,
  input  logic [7:0] mem,
  input  logic [7:0] IN,
  output logic [7:0] OUT
);

  logic [7:0] v_q;
  logic [7:0] x_q;
  logic [7:0] out_q;
  logic [4:0] flags_q;

  opcode_e    op;
  reg_e       d_code;
  reg_e       s_code;
  logic [7:0] d_val;
  logic [7:0] s_val;
  logic [7:0] alu_a;
  logic [7:0] alu_res;
  logic [4:0] alu_flags;
  logic       flag_upd;
  logic       dest_wr;

  assign op     = opcode_e'(instr[7:4]);
  assign d_code = reg_e'(instr[3:2]);
  assign s_code = reg_e'(instr[1:0]);

  always_comb begin
    d_val = IN;
    case (d_code)
      REG_IN:  d_val = IN;
      REG_MEM: d_val = mem;
      REG_V:   d_val = v_q;
      default: d_val = x_q;
    endcase
  end

  always_comb begin
    s_val = IN;
    case (s_code)
      REG_IN:  s_val = IN;
      REG_MEM: s_val = mem;
      REG_V:   s_val = v_q;
      default: s_val = x_q;
    endcase
  end

  // Shifts always operate on V regardless of the d field.
  assign alu_a    = (op == OP_SHF) ? v_q : d_val;
  assign flag_upd = (op == OP_CMP) || instr[7];
  assign dest_wr  = (op == OP_MOV) || (instr[7] && (op != OP_SHF));

  ual_alu u_alu (
    .op         (op),
    .a          (alu_a),
    .b          (s_val),
    .shift_op   (instr[1:0]),
    .result     (alu_res),
    .flags_next (alu_flags)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 8'h00;
      x_q     <= 8'h00;
      out_q   <= 8'h00;
      flags_q <= 5'b00000;
    end else begin
      case (op)
        OP_HIX: x_q[7:4] <= instr[3:0];
        OP_LOX: x_q[3:0] <= instr[3:0];
        OP_HIV: v_q[7:4] <= instr[3:0];
        OP_LOV: v_q[3:0] <= instr[3:0];
        OP_SHF: v_q      <= alu_res;
        default: begin
          if (dest_wr) begin
            case (d_code)
              REG_V:   v_q   <= alu_res;
              REG_X:   x_q   <= alu_res;
              REG_IN:  out_q <= alu_res;
              default: ;
            endcase
          end
        end
      endcase
      if (flag_upd) begin
        flags_q <= alu_flags;
      end
    end
  end

  assign r1    = v_q;
  assign r2    = x_q;
  assign OUT   = out_q;
  assign flags = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_ual.sv
// +--------------------------------------------------------------------+
// | tb_ual : self-checking bench for ual against a behavioural model    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ual;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [7:0] mem = 8'h00;
  logic [7:0] in_p = 8'h00;
  logic [7:0] r1;
  logic [7:0] r2;
  logic [4:0] flags;
  logic [7:0] out_p;

  int checks = 0;
  int errors = 0;

  int m_v, m_x, m_out, m_flags;

  ual dut (
    .ck    (ck),
    .rst_n (rst_n),
    .instr (instr),
    .r1    (r1),
    .r2    (r2),
    .flags (flags),
    .mem   (mem),
    .IN    (in_p),
    .OUT   (out_p)
  );

  always #5 ck = ~ck;

`ifdef UAL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  function automatic int to_signed(input int val);
    return (val >= 128) ? val - 256 : val;
  endfunction

  function automatic int pick(input int code, input int mv, input int mx, input int mm, input int mi);
    case (code)
      0: return mi;
      1: return mm;
      2: return mv;
      default: return mx;
    endcase
  endfunction

  task automatic model_reset();
    m_v = 0; m_x = 0; m_out = 0; m_flags = 0;
  endtask

  // Architectural model: integer arithmetic on the instruction semantics.
  task automatic model_step(input int ins, input int mm, input int mi);
    int op, d, s, a, b, r, c, o, p, t;
    bit upd, wr;
    op = ins / 16; d = (ins / 4) % 4; s = ins % 4;
    a = pick(d, m_v, m_x, mm, mi);
    b = pick(s, m_v, m_x, mm, mi);
    r = 0; c = 0; o = 0; upd = 0; wr = 0;
    case (op)
      1: begin r = b; wr = 1; end
      2, 9: begin
        r = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
        t = to_signed(a) - to_signed(b);
        o = (t > 127 || t < -128) ? 1 : 0;
        upd = 1; wr = (op == 9);
      end
      4: m_x = (ins % 16) * 16 + m_x % 16;
      5: m_x = (m_x / 16) * 16 + ins % 16;
      6: m_v = (ins % 16) * 16 + m_v % 16;
      7: m_v = (m_v / 16) * 16 + ins % 16;
      8: begin
        r = (a + b) % 256; c = (a + b > 255) ? 1 : 0;
        t = to_signed(a) + to_signed(b);
        o = (t > 127 || t < -128) ? 1 : 0;
        upd = 1; wr = 1;
      end
      10: begin
        case (s)
          0: begin r = (m_v * 2) % 256; c = m_v / 128; end
          1: begin r = m_v / 2; c = m_v % 2; end
          2: begin r = (m_v * 2) % 256 + m_v / 128; c = m_v / 128; end
          default: begin r = m_v / 2 + (m_v % 2) * 128; c = m_v % 2; end
        endcase
        m_v = r; upd = 1;
      end
      11: begin r = a & b; upd = 1; wr = 1; end
      12: begin r = a | b; upd = 1; wr = 1; end
      13: begin r = a ^ b; upd = 1; wr = 1; end
      14: begin r = 255 - (a & b); upd = 1; wr = 1; end
      15: begin r = 255 - b; upd = 1; wr = 1; end
      default: ;
    endcase
    if (wr) begin
      case (d)
        0: m_out = r;
        2: m_v = r;
        3: m_x = r;
        default: ;
      endcase
    end
    if (upd) begin
      p = (PAR_EN && ($countones(r[7:0]) % 2 == 0)) ? 1 : 0;
      m_flags = c + 2 * ((r == 0) ? 1 : 0) + 4 * (r / 128) + 8 * o + 16 * p;
    end
  endtask

  task automatic exec(input logic [7:0] ins, input logic [7:0] mm, input logic [7:0] mi);
    instr = ins; mem = mm; in_p = mi;
    @(posedge ck);
    model_step(int'(ins), int'(mm), int'(mi));
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr = 8'h8B;
    #3;
    checks++;
    if ({r1, r2, out_p, flags} !== 29'd0) begin
      errors++;
      $display("FAIL reset_hold got r1=%h r2=%h out=%h flags=%b want all zero", r1, r2, out_p, flags);
    end
    model_reset();
    instr = 8'h00;
    @(negedge ck);
    rst_n = 1'b1;
    exec(8'h00, 8'h00, 8'h00);
    checks++;
    if ({r1, r2, out_p, flags} !== 29'd0) begin
      errors++;
      $display("FAIL reset_release got r1=%h r2=%h out=%h flags=%b want all zero", r1, r2, out_p, flags);
    end
  endtask

  task automatic test_build_add();
    exec(8'h6F, 8'h00, 8'h00);
    exec(8'h77, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'hF7) begin errors++; $display("FAIL build_v got %h want f7", r1); end
    exec(8'h40, 8'h00, 8'h00);
    exec(8'h51, 8'h00, 8'h00);
    checks++;
    if (r2 !== 8'h01) begin errors++; $display("FAIL build_x got %h want 01", r2); end
    exec(8'h8B, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'hF8 || flags[2:0] !== 3'b100) begin
      errors++; $display("FAIL add_vx got r1=%h flags=%b want r1=f8 N=1 Z=0 C=0", r1, flags);
    end
    exec(8'h9B, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'hF7 || flags[0] !== 1'b0) begin
      errors++; $display("FAIL sub_vx got r1=%h flags=%b want r1=f7 C=0", r1, flags);
    end
  endtask

  task automatic test_overflow();
    exec(8'h67, 8'h00, 8'h00);
    exec(8'h7F, 8'h00, 8'h00);
    exec(8'h40, 8'h00, 8'h00);
    exec(8'h51, 8'h00, 8'h00);
    exec(8'h8B, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'h80 || flags[3:0] !== 4'b1100) begin
      errors++; $display("FAIL overflow got r1=%h flags=%b want r1=80 O=1 N=1 Z=0 C=0", r1, flags);
    end
  endtask

  task automatic test_shift();
    logic [7:0] ins_tab [4] = '{8'hA2, 8'hA3, 8'hA0, 8'hA1};
    logic [7:0] val_tab [4] = '{8'h03, 8'h81, 8'h02, 8'h01};
    logic       c_tab   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exec(8'h68, 8'h00, 8'h00);
    exec(8'h71, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      exec(ins_tab[i], 8'h00, 8'h00);
      checks++;
      if (r1 !== val_tab[i] || flags[0] !== c_tab[i]) begin
        errors++;
        $display("FAIL shift_%h got r1=%h C=%b want r1=%h C=%b", ins_tab[i], r1, flags[0], val_tab[i], c_tab[i]);
      end
    end
  endtask

  task automatic test_logic_out();
    logic [4:0] saved;
    exec(8'hDA, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'h00 || flags[1] !== 1'b1 || flags[4] !== PAR_EN) begin
      errors++; $display("FAIL xor_vv got r1=%h flags=%b want r1=00 Z=1 P=%b", r1, flags, PAR_EN);
    end
    exec(8'h63, 8'h00, 8'h00);
    exec(8'h7C, 8'h00, 8'h00);
    exec(8'h12, 8'h00, 8'h00);
    checks++;
    if (out_p !== 8'h3C) begin errors++; $display("FAIL mov_out got %h want 3c", out_p); end
    exec(8'h45, 8'h00, 8'h00);
    exec(8'h55, 8'h00, 8'h00);
    saved = flags;
    exec(8'h1B, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'h55 || flags !== saved) begin
      errors++; $display("FAIL mov_vx got r1=%h flags=%b want r1=55 flags=%b", r1, flags, saved);
    end
  endtask

  task automatic test_async_reset();
    exec(8'h6A, 8'h00, 8'h00);
    exec(8'h43, 8'h00, 8'h00);
    instr = 8'h8B;
    @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({r1, r2, out_p, flags} !== 29'd0) begin
      errors++; $display("FAIL async_reset got r1=%h r2=%h out=%h flags=%b want all zero", r1, r2, out_p, flags);
    end
    model_reset();
    @(negedge ck);
    rst_n = 1'b1;
    exec(8'h8B, 8'h00, 8'h00);
    checks++;
    if (r1 !== 8'h00 || flags[1] !== 1'b1) begin
      errors++; $display("FAIL post_reset_add got r1=%h flags=%b want r1=00 Z=1", r1, flags);
    end
  endtask

  task automatic test_random();
    logic [7:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins = 8'($urandom);
      exec(ins, 8'($urandom), 8'($urandom));
      checks++;
      if (int'(r1) != m_v || int'(r2) != m_x || int'(out_p) != m_out || int'(flags) != m_flags) begin
        errors++;
        $display("FAIL random_%0d instr=%h got v=%h x=%h out=%h f=%b want v=%h x=%h out=%h f=%b",
                 i, ins, r1, r2, out_p, flags, m_v[7:0], m_x[7:0], m_out[7:0], m_flags[4:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_build_add();
    test_overflow();
    test_shift();
    test_logic_out();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
